imem_boot_ctrl: RTL and testbench
=================================

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, external-source byte address of word 0.
REQ-003 SHALL have parameter TIMEOUT, default 64, max cycles waiting for exIns_valid.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock, rising edge; nrst  in  1  async reset, active low.
REQ-005 SHALL have the load-control ports: load_req  in  1  start (re)load pulse; load_len  in  9  words to load.
REQ-006 SHALL have the external-source ports: exIns_valid  in  1  word valid; exIns_in  in  32  word data; exIns_ren  out  1  read request; exIns_addr  out  32  byte address.
REQ-007 SHALL have the core-fetch port: core_pc  in  32  core fetch byte address.
REQ-008 SHALL have the instruction-memory ports: imem_we  out  1  write enable; imem_addr  out  log2(DEPTH)  word address; imem_wdata  out  32  write data.
REQ-009 SHALL have the status ports: core_hold  out  1  stall core; done  out  1  load complete; err  out  1  timeout; word_cnt  out  9  words written.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, RUN, ERR.
REQ-011 IDLE: core_hold=1; load_req -> FETCH with word_cnt=0 and len latched as min(load_len, DEPTH); latched len 0 -> RUN directly.
REQ-012 FETCH: exIns_ren=1, exIns_addr=BASE+4*word_cnt, held stable until exIns_valid; one request outstanding.
REQ-013 exIns_valid in FETCH SHALL, in that same cycle, drive imem_we=1, imem_addr=word_cnt, imem_wdata=exIns_in, then increment word_cnt next edge.
REQ-014 On the accepted word with word_cnt+1==latched len, FSM SHALL go to RUN next edge; exIns_ren low from that edge.
REQ-015 exIns_valid while exIns_ren=0 SHALL be ignored (no write, no count).
REQ-016 Wait counter SHALL clear on each accepted word/FETCH entry; reaching TIMEOUT cycles without valid -> ERR.
REQ-017 RUN: core_hold=0, done=1, imem_we=0, imem_addr=core_pc[log2(DEPTH)+1:2].
REQ-018 ERR: err=1, core_hold=1, exIns_ren=0; only load_req leaves (-> FETCH, err cleared).
REQ-019 load_req in RUN SHALL restart load (-> FETCH, core_hold=1, done=0 next edge).
REQ-020 load_req in FETCH SHALL be ignored; exIns_valid takes effect that cycle.
REQ-021 Outside RUN, imem_addr SHALL be word_cnt; core_pc has no effect.

Reset
REQ-022 nrst low SHALL asynchronously force IDLE, word_cnt=0, wait counter=0, exIns_ren=0, exIns_addr=BASE, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, err=0.
REQ-023 Reset mid-FETCH SHALL abandon the load; no imem write in reset cycle; post-release needs new load_req.

Structure
REQ-024 FSM state enum, DEPTH/TIMEOUT defaults and address-width function SHALL live in shared package core_pkg.
REQ-025 Wait/timeout counter SHALL be a sub-module boot_timeout (clear, enable, expired).
REQ-026 imem address mux SHALL be combinational from state; all other outputs registered or decoded from state.

Verification
REQ-027 load_req, load_len=4, valid one cycle after each ren -> 4 writes at addr 0..3, exIns_addr 0,4,8,C, done=1, core_hold=0.
REQ-028 load_len=300 -> exactly 256 writes, word_cnt=256, then RUN.
REQ-029 load_len=2, no valid for 64 cycles after first ren -> err=1, ERR, no write; later load_req retries.
REQ-030 nrst low at word 3 of 8 -> IDLE instantly, word_cnt=0, exIns_ren=0, core_hold=1.
REQ-031 In RUN core_pc=0x0000_0174 -> imem_addr=0x5D; load_req -> core_hold=1 next cycle, word_cnt=0.
REQ-032 load_len=0 -> RUN next cycle, no exIns_ren pulse; stray valid in IDLE -> no write.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared FSM state, default parameters and width helper for imem_boot_ctrl
//   DEF_DEPTH   default instruction-memory depth in 32-bit words
//   DEF_TIMEOUT default number of cycles to wait for a source word
//   LEN_W       width of load length and word counter
//   addr_w()    word-address width for a given depth
package core_pkg;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_TIMEOUT = 64;
  localparam int LEN_W = 9;
  typedef enum logic [1:0] {IDLE, FETCH, RUN, ERR} boot_state_t;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/boot_timeout.sv
// boot_timeout: counts consecutive cycles spent waiting for a source word
//   clk       rising-edge clock
//   nrst      asynchronous active-low reset
//   i_clear   synchronous clear (outside FETCH or on an accepted word)
//   i_en      count this cycle as a waiting cycle
//   o_expired this is the TIMEOUT-th consecutive waiting cycle
module boot_timeout
  import core_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
  // r_cnt holds completed waiting cycles, so the current one is the last allowed
  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: copies a boot image from an external word source into instruction memory
//   clk, nrst                       clock, asynchronous active-low reset
//   load_req, load_len              (re)load pulse and number of words to load
//   exIns_valid, exIns_in           source word valid and data
//   exIns_ren, exIns_addr           source read request and byte address
//   core_pc                         core fetch byte address, used in RUN only
//   imem_we, imem_addr, imem_wdata  instruction-memory write/fetch port
//   core_hold, done, err, word_cnt  status
module imem_boot_ctrl
  import core_pkg::*;
#(
  parameter int          DEPTH   = DEF_DEPTH,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       load_req,
  input  logic [LEN_W-1:0]           load_len,
  input  logic                       exIns_valid,
  input  logic [31:0]                exIns_in,
  output logic                       exIns_ren,
  output logic [31:0]                exIns_addr,
  input  logic [31:0]                core_pc,
  output logic                       imem_we,
  output logic [addr_w(DEPTH)-1:0]   imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       core_hold,
  output logic                       done,
  output logic                       err,
  output logic [LEN_W-1:0]           word_cnt
);
  localparam int AW = addr_w(DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'((DEPTH > 511) ? 511 : DEPTH);
  boot_state_t r_state, w_state_nxt;
  logic [LEN_W-1:0] r_word_cnt, r_len, w_cnt_nxt, w_len_nxt, w_load_len, w_cnt_inc;
  logic w_fetch, w_start, w_acc, w_expired, w_unused_pc;
  assign w_fetch    = r_state == FETCH;
  // a load request is ignored while a load is in flight
  assign w_start    = load_req && !w_fetch;
  assign w_acc      = w_fetch && exIns_valid;
  assign w_load_len = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign w_cnt_inc  = r_word_cnt + LEN_W'(1);
  boot_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .nrst      (nrst),
    .i_clear   (!w_fetch || exIns_valid),
    .i_en      (w_fetch && !exIns_valid),
    .o_expired (w_expired)
  );
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_word_cnt <= '0;
      r_len      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_cnt_nxt;
      r_len      <= w_len_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_word_cnt;
    w_len_nxt   = r_len;
    if (w_start) begin
      w_cnt_nxt   = '0;
      w_len_nxt   = w_load_len;
      w_state_nxt = (w_load_len == '0) ? RUN : FETCH;
    end else if (w_acc) begin
      w_cnt_nxt   = w_cnt_inc;
      w_state_nxt = (w_cnt_inc == r_len) ? RUN : FETCH;
    end else if (w_expired) begin
      w_state_nxt = ERR;
    end
  end
  assign exIns_ren  = w_fetch;
  assign exIns_addr = BASE + (32'(r_word_cnt) << 2);
  // the write happens in the same cycle the source presents the word
  assign imem_we    = w_acc;
  assign imem_wdata = w_acc ? exIns_in : '0;
  assign imem_addr  = (r_state == RUN) ? core_pc[AW+1:2] : AW'(r_word_cnt);
  assign core_hold  = r_state != RUN;
  assign done       = r_state == RUN;
  assign err        = r_state == ERR;
  assign word_cnt   = r_word_cnt;
  assign w_unused_pc = ^{core_pc[31:AW+2], core_pc[1:0]};
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: scoreboard bench for imem_boot_ctrl
module tb_imem_boot_ctrl;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic clk = 0, nrst = 0, load_req = 0, exIns_valid = 0;
  logic exIns_ren, imem_we, core_hold, done, err;
  logic [8:0] load_len = '0, word_cnt;
  logic [31:0] exIns_in = '0, exIns_addr, core_pc = '0, imem_wdata;
  logic [7:0] imem_addr;
  typedef struct packed {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t sb[$];
  wr_t exp_wr;
  int n_checks = 0, n_fail = 0, n_writes = 0;

  always #5 clk = ~clk;

  imem_boot_ctrl dut (
    .clk(clk), .nrst(nrst), .load_req(load_req), .load_len(load_len),
    .exIns_valid(exIns_valid), .exIns_in(exIns_in), .exIns_ren(exIns_ren),
    .exIns_addr(exIns_addr), .core_pc(core_pc), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
    .done(done), .err(err), .word_cnt(word_cnt)
  );

  always @(negedge clk) begin
    if (imem_we !== 1'b0) begin
      n_writes++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: we=%b addr=%h data=%h, required no write", imem_we, imem_addr, imem_wdata);
      end else begin
        exp_wr = sb.pop_front();
        if (imem_addr !== exp_wr.a || imem_wdata !== exp_wr.d) begin
          n_fail++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h", imem_addr, imem_wdata, exp_wr.a, exp_wr.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_load(input logic [8:0] len);
    load_req = 1;
    load_len = len;
    @(posedge clk); #1;
    load_req = 0;
  endtask

  task automatic serve_word(input int idx, input int gap, output bit ok, output logic [31:0] addr);
    int t;
    t = 0;
    ok = 0;
    @(negedge clk);
    while (exIns_ren !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    addr = exIns_addr;
    if (exIns_ren === 1'b1) begin
      ok = 1;
      @(posedge clk); #1;
      repeat (gap) begin
        @(posedge clk); #1;
      end
      exIns_valid = 1;
      exIns_in = $urandom;
      sb.push_back('{a: 8'(idx), d: exIns_in});
      @(posedge clk); #1;
      exIns_valid = 0;
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({exIns_ren, imem_we, core_hold, done, err} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_flags: ren/we/hold/done/err=%b, required 00100", {exIns_ren, imem_we, core_hold, done, err});
    end
    n_checks++;
    if (exIns_addr !== BASE || imem_addr !== 8'h00 || imem_wdata !== 32'h0 || word_cnt !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_values: exaddr=%h iaddr=%h wdata=%h cnt=%0d, required %h 00 0 0", exIns_addr, imem_addr, imem_wdata, word_cnt, BASE);
    end
    @(negedge clk);
    nrst = 1;
    @(posedge clk); #1;
    n_checks++;
    if (exIns_ren !== 1'b0 || core_hold !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ren=%b hold=%b done=%b, required 0 1 0", exIns_ren, core_hold, done);
    end
  endtask

  task automatic test_zero_len();
    exIns_valid = 1;
    exIns_in = 32'hDEAD_BEEF;
    repeat (2) begin
      @(posedge clk); #1;
    end
    exIns_valid = 0;
    n_checks++;
    if (word_cnt !== 9'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_stray_valid: cnt=%0d done=%b, required 0 0", word_cnt, done);
    end
    load_req = 1;
    load_len = 9'd0;
    @(negedge clk);
    n_checks++;
    if (exIns_ren !== 1'b0 || core_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_len_req_cycle: ren=%b hold=%b, required 0 1", exIns_ren, core_hold);
    end
    @(posedge clk); #1;
    load_req = 0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || core_hold !== 1'b0 || exIns_ren !== 1'b0 || word_cnt !== 9'd0) begin
      n_fail++;
      $display("FAIL zero_len_run: done=%b hold=%b ren=%b cnt=%0d, required 1 0 0 0", done, core_hold, exIns_ren, word_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int w0;
    bit ok;
    logic [31:0] a;
    w0 = n_writes;
    start_load(9'd4);
    for (int i = 0; i < 4; i++) begin
      serve_word(i, 0, ok, a);
      n_checks++;
      if (!ok || a !== BASE + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL basic_req%0d: ren_seen=%b addr=%h, required 1 %h", i, ok, a, BASE + 32'(4 * i));
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || core_hold !== 1'b0 || exIns_ren !== 1'b0 || word_cnt !== 9'd4) begin
      n_fail++;
      $display("FAIL basic_done: done=%b hold=%b ren=%b cnt=%0d, required 1 0 0 4", done, core_hold, exIns_ren, word_cnt);
    end
    n_checks++;
    if (n_writes - w0 !== 4 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL basic_writes: writes=%0d pending=%0d, required 4 0", n_writes - w0, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clamp();
    int w0;
    bit ok;
    logic [31:0] a;
    w0 = n_writes;
    start_load(9'd300);
    for (int i = 0; i < 256; i++) begin
      serve_word(i, 0, ok, a);
      n_checks++;
      if (!ok || a !== BASE + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL clamp_req%0d: ren_seen=%b addr=%h, required 1 %h", i, ok, a, BASE + 32'(4 * i));
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || exIns_ren !== 1'b0 || word_cnt !== 9'd256 || n_writes - w0 !== 256) begin
      n_fail++;
      $display("FAIL clamp_done: done=%b ren=%b cnt=%0d writes=%0d, required 1 0 256 256", done, exIns_ren, word_cnt, n_writes - w0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int w0, c;
    bit ok;
    logic [31:0] a;
    w0 = n_writes;
    c = 0;
    start_load(9'd2);
    while (err !== 1'b1 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    n_checks++;
    if (c !== 64) begin
      n_fail++;
      $display("FAIL timeout_cycles: err after %0d cycles, required 64", c);
    end
    n_checks++;
    if (err !== 1'b1 || core_hold !== 1'b1 || exIns_ren !== 1'b0 || done !== 1'b0 || n_writes !== w0) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b hold=%b ren=%b done=%b writes=%0d, required 1 1 0 0 0", err, core_hold, exIns_ren, done, n_writes - w0);
    end
    exIns_valid = 1;
    exIns_in = 32'h1234_5678;
    repeat (2) begin
      @(posedge clk); #1;
    end
    exIns_valid = 0;
    n_checks++;
    if (err !== 1'b1 || word_cnt !== 9'd0) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b cnt=%0d, required 1 0", err, word_cnt);
    end
    start_load(9'd2);
    n_checks++;
    if (err !== 1'b0 || exIns_ren !== 1'b1) begin
      n_fail++;
      $display("FAIL retry_start: err=%b ren=%b, required 0 1", err, exIns_ren);
    end
    for (int i = 0; i < 2; i++) begin
      serve_word(i, 2, ok, a);
      n_checks++;
      if (!ok || a !== BASE + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL retry_req%0d: ren_seen=%b addr=%h, required 1 %h", i, ok, a, BASE + 32'(4 * i));
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || word_cnt !== 9'd2 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL retry_done: done=%b cnt=%0d err=%b, required 1 2 0", done, word_cnt, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_run_pc();
    bit ok;
    logic [31:0] a;
    core_pc = 32'h0000_0174;
    @(negedge clk);
    n_checks++;
    if (imem_addr !== 8'h5D) begin
      n_fail++;
      $display("FAIL run_pc_174: imem_addr=%h, required 5d", imem_addr);
    end
    core_pc = 32'h0000_03FC;
    @(negedge clk);
    n_checks++;
    if (imem_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL run_pc_3fc: imem_addr=%h, required ff", imem_addr);
    end
    @(posedge clk); #1;
    start_load(9'd3);
    @(negedge clk);
    n_checks++;
    if (core_hold !== 1'b1 || done !== 1'b0 || word_cnt !== 9'd0 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reload_from_run: hold=%b done=%b cnt=%0d iaddr=%h, required 1 0 0 00", core_hold, done, word_cnt, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      serve_word(i, 1, ok, a);
      n_checks++;
      if (!ok || a !== BASE + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL reload_req%0d: ren_seen=%b addr=%h, required 1 %h", i, ok, a, BASE + 32'(4 * i));
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || word_cnt !== 9'd3 || imem_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL reload_done: done=%b cnt=%0d iaddr=%h, required 1 3 ff", done, word_cnt, imem_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = n_writes;
    start_load(9'd6);
    @(negedge clk);
    n_checks++;
    if (exIns_ren !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ren: ren=%b, required 1", exIns_ren);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (exIns_addr !== BASE + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL b2b_addr%0d: addr=%h, required %h", i, exIns_addr, BASE + 32'(4 * i));
      end
      exIns_valid = 1;
      exIns_in = $urandom;
      sb.push_back('{a: 8'(i), d: exIns_in});
      load_req = (i == 2);
      load_len = 9'd1;
      @(posedge clk); #1;
    end
    exIns_valid = 0;
    load_req = 0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || word_cnt !== 9'd6 || n_writes - w0 !== 6 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b cnt=%0d writes=%0d pending=%0d, required 1 6 6 0", done, word_cnt, n_writes - w0, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int w0;
    bit ok;
    logic [31:0] a;
    w0 = n_writes;
    start_load(9'd8);
    for (int i = 0; i < 3; i++) begin
      serve_word(i, 0, ok, a);
      n_checks++;
      if (!ok || a !== BASE + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL mid_req%0d: ren_seen=%b addr=%h, required 1 %h", i, ok, a, BASE + 32'(4 * i));
      end
    end
    n_checks++;
    if (word_cnt !== 9'd3 || exIns_ren !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_before_reset: cnt=%0d ren=%b, required 3 1", word_cnt, exIns_ren);
    end
    exIns_valid = 1;
    exIns_in = $urandom;
    #2 nrst = 0;
    #1;
    n_checks++;
    if (exIns_ren !== 1'b0 || word_cnt !== 9'd0 || core_hold !== 1'b1 || imem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: ren=%b cnt=%0d hold=%b we=%b done=%b err=%b, required 0 0 1 0 0 0", exIns_ren, word_cnt, core_hold, imem_we, done, err);
    end
    exIns_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    nrst = 1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (exIns_ren !== 1'b0 || core_hold !== 1'b1 || word_cnt !== 9'd0) begin
      n_fail++;
      $display("FAIL mid_post_release: ren=%b hold=%b cnt=%0d, required 0 1 0", exIns_ren, core_hold, word_cnt);
    end
    @(posedge clk); #1;
    start_load(9'd2);
    for (int i = 0; i < 2; i++) begin
      serve_word(i, 0, ok, a);
      n_checks++;
      if (!ok || a !== BASE + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL mid_reload_req%0d: ren_seen=%b addr=%h, required 1 %h", i, ok, a, BASE + 32'(4 * i));
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || word_cnt !== 9'd2 || n_writes - w0 !== 5 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_reload_done: done=%b cnt=%0d writes=%0d pending=%0d, required 1 2 5 0", done, word_cnt, n_writes - w0, sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_basic();
    test_clamp();
    test_timeout();
    test_run_pc();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
